lm_sm_sequencer: RTL and testbench
==================================

Name: lm_sm_sequencer

Overview:
- Registered FSM that expands one LM (opcode 0110) or SM (opcode 0111) instruction into one micro-op per set bit of ir[7:0].
- Sits in the ID stage, between IF_ID and ID_RR.
- Drives per-micro-op register address, memory offset and LM/SM flags into ID_RR, and stalls fetch while a multi-transfer sequence is in flight.

Parameters:
- NREGS, 8, number of architectural registers and width of the register-list field.
- ADDR_W, 16, width of the address-offset output.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- ir_valid  input  1  ir holds a live instruction from IF_ID
- ir  input  16  instruction word
- hold  input  1  downstream bubble (RR_nop); freezes current micro-op
- flush  input  1  branch/jump/R7 redirect; abort sequence
- uop_valid  output  1  micro-op outputs are meaningful this cycle
- uop_is_lm  output  1  current micro-op is an LM transfer
- uop_is_sm  output  1  current micro-op is an SM transfer
- uop_reg  output  3  register read (SM) or written (LM)
- uop_offset  output  ADDR_W  transfer index, added to base in EX
- base_reg  output  3  ir[11:9] latched at accept
- uop_last  output  1  current micro-op is the final transfer
- fetch_stall  output  1  hold PC and IF_ID
- busy  output  1  FSM in SEQ

Behaviour:
- Reset: state=IDLE; all outputs 0; internal pending mask=0; counter=0.
- Accept condition: state=IDLE and ir_valid and ir[15:12] is 0110/0111 and !flush.
- Register-list order:
  - Bit i of ir[7:0] selects Ri.
  - Lowest set index is issued first.
  - Offsets are 0,1,2,... in issue order, independent of register index.
- States:
  - IDLE: no micro-op.
    - On accept with nonzero list: latch pending mask=ir[7:0], base_reg, LM/SM kind; go to SEQ.
    - First micro-op appears registered on the next cycle.
    - On accept with zero list: stay IDLE; no micro-op. The instruction retires as a NOP.
  - SEQ: outputs present lowest set bit of pending mask, with uop_valid=1.
    - When !hold: clear that bit; offset+1.
    - If the cleared bit was the last one: go to IDLE and drop uop_valid the next cycle.
    - When hold=1: all outputs and state frozen.
- uop_last (combinational from mask) = exactly one bit pending.
- fetch_stall (combinational):
  - Asserted when accept fires with nonzero list.
  - Asserted in SEQ, except in the cycle where uop_last=1 and hold=0, so fetch resumes in that cycle.
- Flush has priority over hold and accept in every state:
  - Next cycle: IDLE, mask cleared, all outputs 0.
  - fetch_stall=0 in the flush cycle.
- The offset counter is ADDR_W wide and zero-extended. It can never exceed NREGS-1, so wrap cannot occur; the design asserts this in simulation.
- ir changes while in SEQ are ignored; only latched state is used.
- rst mid-sequence behaves identically to flush, plus the reset values above.

Optional Feature:
- Macro LMSM_R7_REDIRECT_EN.
- When defined:
  - Adds output r7_redirect (1 bit), high on any LM micro-op with uop_reg=7 and uop_valid=1 and !hold.
  - Forces that micro-op to be treated as last: remaining mask bits are discarded, next state is IDLE, and fetch_stall stays high in that cycle.
  - The pipeline then redirects the PC from memory data.
- When undefined:
  - The port is absent.
  - R7 in an LM list is an ordinary transfer with no special sequencing.

Decomposition:
- Shared package iitb_pkg:
  - Opcode constants OP_LM=4'b0110, OP_SM=4'b0111.
  - State enum {IDLE, SEQ}.
  - NREGS default.
- One sub-module: lmsm_prio_enc.
  - Combinational lowest-set-bit encoder over NREGS bits.
  - Outputs index, found, onehot-clear mask.
  - Instantiated once for the pending mask.

Test Plan:
- LM, ir=16'h6_2A5 (base R1, list 8'hA5), hold=0 → micro-ops R0/off0, R2/off1, R5/off2, R7/off3 on four consecutive cycles.
  - uop_last only on R7.
  - fetch_stall high from the accept cycle through the R5 cycle, low in the R7 cycle.
- SM, list 8'h06, with hold=1 for 2 cycles during the R1 micro-op → R1/off0 held 3 cycles, then R2/off1 with uop_last=1, then IDLE.
- LM with list 8'h00 → no uop_valid, fetch_stall never asserted, busy stays 0.
- SM, list 8'hFF, flush asserted during the third micro-op (R2) → next cycle all outputs 0, busy=0, and a following ADD is not stalled.
- rst asserted during the second micro-op of LM 8'h0F → next cycle outputs 0. Then a new LM, list 8'h80, yields a single R7/off0 micro-op.
- With LMSM_R7_REDIRECT_EN, LM list 8'hC1 → R0/off0, R6/off1, R7/off2 with r7_redirect=1, then IDLE.
  - With LM list 8'h81 → R0, then R7 with r7_redirect=1 and uop_last=1.

Source files
------------

// File: rtl/iitb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iitb_pkg
// Description : Shared opcodes, FSM state type and sizing for the LM/SM
//               expansion logic in the ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
package iitb_pkg;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    localparam int NREGS_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lmsm_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : lmsm_prio_enc
// Description : Combinational lowest-set-bit encoder; returns the index of the
//               lowest set bit and the mask with that bit cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module lmsm_prio_enc #(
    parameter int NREGS = 8,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic [NREGS-1:0] i_mask,
    output logic [IDX_W-1:0] o_index,
    output logic             o_found,
    output logic [NREGS-1:0] o_clr_mask
);

    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (i_mask[i] && !o_found) begin
                o_index = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit
    assign o_clr_mask = i_mask & (i_mask - NREGS'(1));

endmodule
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lm_sm_sequencer
// Description : Expands one LM/SM instruction into one micro-op per set bit of
//               the register list, stalling fetch while the sequence runs.
//               Optional macro LMSM_R7_REDIRECT_EN adds r7_redirect and ends
//               an LM sequence at its R7 transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module lm_sm_sequencer
    import iitb_pkg::*;
#(
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_valid,
    input  logic [15:0]       ir,
    input  logic              hold,
    input  logic              flush,
    output logic              uop_valid,
    output logic              uop_is_lm,
    output logic              uop_is_sm,
    output logic [2:0]        uop_reg,
    output logic [ADDR_W-1:0] uop_offset,
    output logic [2:0]        base_reg,
    output logic              uop_last,
`ifdef LMSM_R7_REDIRECT_EN
    output logic              r7_redirect,
`endif
    output logic              fetch_stall,
    output logic              busy
);

    localparam int                IDX_W     = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] c_nregs_w = ADDR_W'(NREGS);

    state_t            r_state, w_state_n;
    logic [NREGS-1:0]  r_mask, w_mask_n;
    logic [ADDR_W-1:0] r_offset, w_offset_n;
    logic [2:0]        r_base, w_base_n;
    logic              r_is_lm, w_is_lm_n;

    logic [IDX_W-1:0]  w_idx;
    logic              w_found;
    logic [NREGS-1:0]  w_clr_mask;
    logic              w_seq, w_is_op, w_accept, w_list_nz, w_last_bit, w_redirect;
    logic              w_unused;

    lmsm_prio_enc #(.NREGS(NREGS), .IDX_W(IDX_W)) u_prio_enc (
        .i_mask     (r_mask),
        .o_index    (w_idx),
        .o_found    (w_found),
        .o_clr_mask (w_clr_mask)
    );

    assign w_unused   = ir[8];
    assign w_seq      = (r_state == SEQ);
    assign w_is_op    = (ir[15:12] == OP_LM) || (ir[15:12] == OP_SM);
    assign w_accept   = (r_state == IDLE) && ir_valid && w_is_op && !flush;
    assign w_list_nz  = |ir[NREGS-1:0];
    assign w_last_bit = w_found && (w_clr_mask == '0);

`ifdef LMSM_R7_REDIRECT_EN
    // Loading R7 from memory redirects the PC, so nothing after it may issue
    assign w_redirect  = w_seq && r_is_lm && (w_idx == IDX_W'(7)) && !hold;
    assign r7_redirect = w_redirect;
`else
    assign w_redirect  = 1'b0;
`endif

    always_comb begin
        w_state_n  = r_state;
        w_mask_n   = r_mask;
        w_offset_n = r_offset;
        w_base_n   = r_base;
        w_is_lm_n  = r_is_lm;
        if (flush) begin
            w_state_n  = IDLE;
            w_mask_n   = '0;
            w_offset_n = '0;
            w_base_n   = '0;
            w_is_lm_n  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_list_nz) begin
                        w_state_n  = SEQ;
                        w_mask_n   = ir[NREGS-1:0];
                        w_offset_n = '0;
                        w_base_n   = ir[11:9];
                        w_is_lm_n  = (ir[15:12] == OP_LM);
                    end
                end
                SEQ: begin
                    if (!hold) begin
                        if (w_last_bit || w_redirect) begin
                            w_state_n  = IDLE;
                            w_mask_n   = '0;
                            w_offset_n = '0;
                        end else begin
                            w_mask_n   = w_clr_mask;
                            w_offset_n = r_offset + ADDR_W'(1);
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mask   <= '0;
            r_offset <= '0;
            r_base   <= '0;
            r_is_lm  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_mask   <= w_mask_n;
            r_offset <= w_offset_n;
            r_base   <= w_base_n;
            r_is_lm  <= w_is_lm_n;
        end
    end

    // Offset counts at most popcount(list)-1, so it can never wrap
    a_offset_range: assert property (@(posedge clk) disable iff (rst) r_offset < c_nregs_w);

    assign uop_valid   = w_seq;
    assign uop_is_lm   = w_seq && r_is_lm;
    assign uop_is_sm   = w_seq && !r_is_lm;
    assign uop_reg     = w_seq ? 3'(w_idx) : 3'd0;
    assign uop_offset  = w_seq ? r_offset : '0;
    assign base_reg    = w_seq ? r_base : 3'd0;
    assign uop_last    = w_seq && w_last_bit;
    assign busy        = w_seq;
    assign fetch_stall = !flush && !rst &&
                         ((w_accept && w_list_nz) ||
                          (w_seq && !(w_last_bit && !hold && !w_redirect)));

endmodule
`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lm_sm_sequencer
// Description : Self-checking bench: directed vector table plus randomized
//               traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lm_sm_sequencer;

    localparam bit REDIR =
`ifdef LMSM_R7_REDIRECT_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ir_valid, hold, flush;
    logic [15:0] ir;
    logic        uop_valid, uop_is_lm, uop_is_sm, uop_last, fetch_stall, busy;
    logic [2:0]  uop_reg, base_reg;
    logic [15:0] uop_offset;
    logic        redir_w;

    always #5 clk = ~clk;

    lm_sm_sequencer #(.NREGS(8), .ADDR_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .hold        (hold),
        .flush       (flush),
        .uop_valid   (uop_valid),
        .uop_is_lm   (uop_is_lm),
        .uop_is_sm   (uop_is_sm),
        .uop_reg     (uop_reg),
        .uop_offset  (uop_offset),
        .base_reg    (base_reg),
        .uop_last    (uop_last),
`ifdef LMSM_R7_REDIRECT_EN
        .r7_redirect (redir_w),
`endif
        .fetch_stall (fetch_stall),
        .busy        (busy)
    );

`ifndef LMSM_R7_REDIRECT_EN
    assign redir_w = 1'b0;
`endif

    // {valid, is_lm, is_sm, reg, offset, base, last, stall, busy, redirect}
    logic [28:0] act;
    assign act = {uop_valid, uop_is_lm, uop_is_sm, uop_reg, uop_offset,
                  base_reg, uop_last, fetch_stall, busy, redir_w};

    typedef struct {
        logic        v;
        logic [15:0] ir;
        logic        h, f, r;
        logic [28:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [28:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Row with no micro-op in flight
    task automatic row_i(input logic v, input logic [15:0] i, input logic h, f, r, stall);
        vec_t e;
        e.v = v; e.ir = i; e.h = h; e.f = f; e.r = r;
        e.exp = {3'b000, 3'd0, 16'd0, 3'd0, 1'b0, stall, 1'b0, 1'b0};
        tbl.push_back(e);
    endtask

    // Row with a live micro-op; ir carries noise that must be ignored
    task automatic row_u(input logic h, f, r, lm, input logic [2:0] rg, input int off,
                         input logic [2:0] base, input logic last, stall, rd);
        vec_t e;
        e.v = 1'b1; e.ir = 16'h7FFF; e.h = h; e.f = f; e.r = r;
        e.exp = {1'b1, lm, !lm, rg, 16'(off), base, last, stall, 1'b1, rd};
        tbl.push_back(e);
    endtask

    // Reference model: queue of pending register numbers in issue order
    int          mq[$];
    int          mk;
    logic        mlm;
    logic [2:0]  mbase;
    logic        m_busy, m_last, m_acc, m_redir, m_stall;
    logic [2:0]  m_reg;
    logic [28:0] m_exp;

    task automatic model_eval();
        m_busy  = (mq.size() > 0);
        m_reg   = m_busy ? 3'(mq[0]) : 3'd0;
        m_last  = (mq.size() == 1);
        m_acc   = !m_busy && ir_valid && (ir[15:12] == 4'h6 || ir[15:12] == 4'h7) && !flush;
        m_redir = REDIR && m_busy && mlm && (m_reg == 3'd7) && !hold;
        m_stall = (flush || rst) ? 1'b0 :
                  ((m_acc && ir[7:0] != 8'h00) || (m_busy && !(m_last && !hold && !m_redir)));
        m_exp   = {m_busy, m_busy && mlm, m_busy && !mlm, m_reg,
                   m_busy ? 16'(mk) : 16'd0, m_busy ? mbase : 3'd0,
                   m_last, m_stall, m_busy, m_redir};
    endtask

    task automatic model_update();
        if (rst || flush) begin
            mq.delete();
            mk = 0;
        end else if (m_busy && !hold) begin
            if (m_redir) mq.delete();
            else void'(mq.pop_front());
            mk++;
            if (mq.size() == 0) mk = 0;
        end else if (m_acc && ir[7:0] != 8'h00) begin
            for (int i = 0; i < 8; i++) if (ir[i]) mq.push_back(i);
            mk    = 0;
            mlm   = (ir[15:12] == 4'h6);
            mbase = ir[11:9];
        end
    endtask

    initial begin
        rst = 1'b1; ir_valid = 1'b0; ir = 16'h0; hold = 1'b0; flush = 1'b0;
        mk = 0; mlm = 1'b0; mbase = 3'd0;
        @(posedge clk); @(posedge clk); #1;
        check("reset", 29'd0);
        rst = 1'b0;

        // LM R1, list A5
        row_i(1, 16'h62A5, 0, 0, 0, 1);
        row_u(0, 0, 0, 1, 3'd0, 0, 3'd1, 0, 1, 0);
        row_u(0, 0, 0, 1, 3'd2, 1, 3'd1, 0, 1, 0);
        row_u(0, 0, 0, 1, 3'd5, 2, 3'd1, 0, 1, 0);
        row_u(0, 0, 0, 1, 3'd7, 3, 3'd1, 1, REDIR, REDIR);
        row_i(0, 16'h0000, 0, 0, 0, 0);
        // SM R3, list 06, hold two cycles on R1
        row_i(1, 16'h7606, 0, 0, 0, 1);
        row_u(1, 0, 0, 0, 3'd1, 0, 3'd3, 0, 1, 0);
        row_u(1, 0, 0, 0, 3'd1, 0, 3'd3, 0, 1, 0);
        row_u(0, 0, 0, 0, 3'd1, 0, 3'd3, 0, 1, 0);
        row_u(0, 0, 0, 0, 3'd2, 1, 3'd3, 1, 0, 0);
        row_i(0, 16'h0000, 0, 0, 0, 0);
        // LM with empty list retires as a NOP
        row_i(1, 16'h6200, 0, 0, 0, 0);
        row_i(0, 16'h0000, 0, 0, 0, 0);
        // SM R2, list FF, flush on R2, then an ADD
        row_i(1, 16'h74FF, 0, 0, 0, 1);
        row_u(0, 0, 0, 0, 3'd0, 0, 3'd2, 0, 1, 0);
        row_u(0, 0, 0, 0, 3'd1, 1, 3'd2, 0, 1, 0);
        row_u(0, 1, 0, 0, 3'd2, 2, 3'd2, 0, 0, 0);
        row_i(1, 16'h0123, 0, 0, 0, 0);
        row_i(0, 16'h0000, 0, 0, 0, 0);
        // LM R5, list 0F, reset on R1, then LM list 80
        row_i(1, 16'h6A0F, 0, 0, 0, 1);
        row_u(0, 0, 0, 1, 3'd0, 0, 3'd5, 0, 1, 0);
        row_u(0, 0, 1, 1, 3'd1, 1, 3'd5, 0, 0, 0);
        row_i(1, 16'h6080, 0, 0, 0, 1);
        row_u(0, 0, 0, 1, 3'd7, 0, 3'd0, 1, REDIR, REDIR);
        row_i(0, 16'h0000, 0, 0, 0, 0);
        // LM list C1 and 81: R7 is the final transfer
        row_i(1, 16'h60C1, 0, 0, 0, 1);
        row_u(0, 0, 0, 1, 3'd0, 0, 3'd0, 0, 1, 0);
        row_u(0, 0, 0, 1, 3'd6, 1, 3'd0, 0, 1, 0);
        row_u(0, 0, 0, 1, 3'd7, 2, 3'd0, 1, REDIR, REDIR);
        row_i(0, 16'h0000, 0, 0, 0, 0);
        row_i(1, 16'h6081, 0, 0, 0, 1);
        row_u(0, 0, 0, 1, 3'd0, 0, 3'd0, 0, 1, 0);
        row_u(0, 0, 0, 1, 3'd7, 1, 3'd0, 1, REDIR, REDIR);
        row_i(0, 16'h0000, 0, 0, 0, 0);

        foreach (tbl[n]) begin
            ir_valid = tbl[n].v; ir = tbl[n].ir;
            hold = tbl[n].h; flush = tbl[n].f; rst = tbl[n].r;
            #4;
            check($sformatf("vec%0d", n), tbl[n].exp);
            @(posedge clk); #1;
        end

        // Randomized traffic; the table leaves the design idle, matching the empty model
        for (int n = 0; n < 800; n++) begin
            logic [3:0] op;
            logic [7:0] lst;
            case ($urandom_range(0, 3))
                0:       op = 4'h6;
                1:       op = 4'h7;
                default: op = 4'($urandom);
            endcase
            lst      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ir       = {op, 4'($urandom), lst};
            ir_valid = 1'($urandom_range(0, 1));
            hold     = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            #4;
            model_eval();
            check($sformatf("rand%0d", n), m_exp);
            @(posedge clk);
            model_update();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
